imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 131 +++++++++++++
 tb/tb_imem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Brief    : Single-outstanding instruction-memory fetch responder with a
//            program-load write port and fixed response latency.
//            Define IMEM_ALIGN_CHECK_EN to flag non-word-aligned fetches.
// Revision : 1.0  initial release
// ============================================================================
module imem_responder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  input  logic [WIDTH-1:0] i_req_addr,
  output logic             o_req_ready,
  output logic             o_rsp_valid,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_err,
  input  logic             i_rsp_ready,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data
);

  localparam int IDX_W = WIDTH - 2;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [IDX_W-1:0] c_depth    = IDX_W'(DEPTH);
  localparam logic [1:0]       c_cnt_init = 2'((LATENCY > 1) ? LATENCY - 2 : 0);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [1:0]       cnt_q,   cnt_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             err_q,   err_d;

  logic [IDX_W-1:0] w_req_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_misaligned;
  logic             w_req_err;
  logic             w_wr_in_range;
  logic [WIDTH-1:0] w_rd_word;
  logic             w_unused;

  assign w_req_idx     = i_req_addr[WIDTH-1:2];
  assign w_wr_idx      = i_wr_addr[WIDTH-1:2];
  assign w_wr_in_range = (w_wr_idx < c_depth);
  assign w_rd_word     = mem_q[w_req_idx[AW-1:0]];
  assign w_unused      = ^{i_wr_addr[1:0], i_req_addr[1:0]};

`ifdef IMEM_ALIGN_CHECK_EN
  assign w_misaligned = (i_req_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_req_err = (w_req_idx >= c_depth) || w_misaligned;

  // Memory has no reset so a program survives a core reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && w_wr_in_range) begin
      mem_q[w_wr_idx[AW-1:0]] <= i_wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      c_st_idle: begin
        if (i_req_valid) begin
          data_d  = w_req_err ? '0 : w_rd_word;
          err_d   = w_req_err;
          cnt_d   = c_cnt_init;
          state_d = (LATENCY == 1) ? c_st_resp : c_st_wait;
        end
      end
      c_st_wait: begin
        if (cnt_q == 2'd0) begin
          state_d = c_st_resp;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      c_st_resp: begin
        if (i_rsp_ready) begin
          state_d = c_st_idle;
          data_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = c_st_idle;
        cnt_d   = 2'd0;
        data_d  = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= c_st_idle;
      cnt_q   <= 2'd0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign o_req_ready = (state_q == c_st_idle) && !i_rst;
  assign o_rsp_valid = (state_q == c_st_resp);
  assign o_rsp_data  = o_rsp_valid ? data_q : '0;
  assign o_rsp_err   = o_rsp_valid && err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_responder
// Brief    : Self-checking bench for imem_responder against a word-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_responder;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_req_valid;
  logic [WIDTH-1:0] i_req_addr;
  logic             o_req_ready;
  logic             o_rsp_valid;
  logic [WIDTH-1:0] o_rsp_data;
  logic             o_rsp_err;
  logic             i_rsp_ready;
  logic             i_wr_en;
  logic [WIDTH-1:0] i_wr_addr;
  logic [WIDTH-1:0] i_wr_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];

  imem_responder #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err),
    .i_rsp_ready (i_rsp_ready),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Model: {err, data} for a fetch of a byte address.
  function automatic logic [32:0] ref_fetch(input logic [31:0] addr);
    int unsigned idx;
    bit          bad;
    idx = addr >> 2;
    bad = (idx >= DEPTH);
`ifdef IMEM_ALIGN_CHECK_EN
    if (addr % 4 != 0) bad = 1'b1;
`endif
    if (bad) return {1'b1, 32'h0};
    return {1'b0, ref_mem[idx]};
  endfunction

  function automatic void ref_write(input logic [31:0] addr, input logic [31:0] data);
    int unsigned idx;
    idx = addr >> 2;
    if (idx < DEPTH) ref_mem[idx] = data;
  endfunction

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    i_wr_en   = 1'b1;
    i_wr_addr = addr;
    i_wr_data = data;
    ref_write(addr, data);
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic do_req(input logic [31:0] addr, input int hold, input bit same_wr,
                        input logic [31:0] wr_data, input string tag);
    logic [32:0] exp;
    logic [31:0] waddr;
    logic [31:0] wdata;
    chk({tag, ":req_ready"}, 32'(o_req_ready), 32'd1);
    exp         = ref_fetch(addr);
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    if (same_wr) begin
      i_wr_en   = 1'b1;
      i_wr_addr = addr;
      i_wr_data = wr_data;
      ref_write(addr, wr_data);
    end
    @(negedge clk);
    i_wr_en = 1'b0;
    for (int k = 1; k < LATENCY; k++) begin
      i_req_valid = 1'($urandom_range(0, 1));
      i_req_addr  = $urandom;
      chk({tag, ":early_valid"}, 32'(o_rsp_valid), 32'd0);
      chk({tag, ":early_data"}, o_rsp_data, 32'd0);
      @(negedge clk);
    end
    chk({tag, ":valid"}, 32'(o_rsp_valid), 32'd1);
    chk({tag, ":data"}, o_rsp_data, exp[31:0]);
    chk({tag, ":err"}, 32'(o_rsp_err), 32'(exp[32]));
    for (int h = 0; h < hold; h++) begin
      i_req_valid = 1'b1;
      i_req_addr  = $urandom_range(0, DEPTH - 1) * 4;
      waddr       = $urandom_range(0, 1) ? 32'($urandom_range(0, DEPTH - 1) * 4) : $urandom;
      wdata       = $urandom;
      i_wr_en     = 1'b1;
      i_wr_addr   = waddr;
      i_wr_data   = wdata;
      ref_write(waddr, wdata);
      @(negedge clk);
      i_wr_en = 1'b0;
      chk({tag, ":stall_ready"}, 32'(o_req_ready), 32'd0);
      chk({tag, ":stall_valid"}, 32'(o_rsp_valid), 32'd1);
      chk({tag, ":stall_data"}, o_rsp_data, exp[31:0]);
      chk({tag, ":stall_err"}, 32'(o_rsp_err), 32'(exp[32]));
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    chk({tag, ":done_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, ":done_data"}, o_rsp_data, 32'd0);
    chk({tag, ":done_err"}, 32'(o_rsp_err), 32'd0);
    chk({tag, ":done_ready"}, 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] addr;
    int          sel;
    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_rsp_ready = 1'b0;
    i_wr_en     = 1'b0;
    i_wr_addr   = '0;
    i_wr_data   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(o_req_ready), 32'd0);
    chk("rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_data", o_rsp_data, 32'd0);
    chk("rst_err", 32'(o_rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(o_req_ready), 32'd1);

    // Program load
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3)      write_word(32'(i * 4), 32'h8C22_0004);
      else if (i == 4) write_word(32'(i * 4), 32'hDEAD_BEEF);
      else             write_word(32'(i * 4), $urandom);
    end

    do_req(32'h0000_000C, 0, 1'b0, 32'h0, "basic_word3");
    chk("word3_value", ref_mem[3], 32'h8C22_0004);
    do_req(32'h0000_000C, 5, 1'b0, 32'h0, "backpressure");

    do_req(32'h0000_0400, 0, 1'b0, 32'h0, "oob_req");
    write_word(32'h0000_0400, 32'hA5A5_A5A5);
    do_req(32'h0000_0000, 0, 1'b0, 32'h0, "oob_write_word0");
    do_req(32'h0000_03FC, 1, 1'b0, 32'h0, "last_word");

    write_word(32'h0000_0010, 32'hDEAD_BEEF);
    do_req(32'h0000_0010, 0, 1'b1, 32'h1111_1111, "same_edge_old");
    do_req(32'h0000_0010, 0, 1'b0, 32'h0, "same_edge_new");

    write_word(32'h0000_000C, 32'h8C22_0004);
    do_req(32'h0000_000E, 0, 1'b0, 32'h0, "misaligned");

    // Reset while a fetch is in flight
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_000C;
    @(negedge clk);
    i_req_valid = 1'b0;
    rst         = 1'b1;
    #1;
    chk("midrst_valid", 32'(o_rsp_valid), 32'd0);
    chk("midrst_ready", 32'(o_req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_valid", 32'(o_rsp_valid), 32'd0);
      chk("rst_hold_data", o_rsp_data, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_valid", 32'(o_rsp_valid), 32'd0);
    do_req(32'h0000_000C, 0, 1'b0, 32'h0, "mem_kept");

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      addr = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(0, 3));
      else if (sel < 9) addr = 32'($urandom_range(DEPTH, 32'h0FFF_FFFF)) << 2;
      else              addr = $urandom;
      do_req(addr, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
